// File: rtl/ram_pkg.sv
// Shared constants and FSM state type for the RAM-backed FIFO controller.
package ram_pkg;

    localparam int ABITS = 5;
    localparam int DBITS = 9;
    localparam int DEPTH = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fifo_state_t;

endpackage

// File: rtl/ram_fifo_ctrl.sv
// Turns a 32x9 single-port RAM into a valid/ready FIFO, with a zeroing sweep.
// Handshakes: a transfer happens on a rising edge where valid && ready are both high.
module ram_fifo_ctrl #(
    parameter int ABITS = ram_pkg::ABITS,
    parameter int DBITS = ram_pkg::DBITS,
    parameter int DEPTH = ram_pkg::DEPTH
) (
    input  logic             clk,
    input  logic             res,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [DBITS-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [DBITS-1:0] pop_data,
    input  logic             clear,
    output logic             busy,
    output logic [ABITS:0]   count,
    output logic             full,
    output logic             empty,
    output logic             ram_wr,
    output logic [ABITS-1:0] ram_addr,
    output logic [DBITS-1:0] ram_din,
    input  logic [DBITS-1:0] ram_dout
);
    import ram_pkg::*;

    fifo_state_t      state_q, state_d;
    logic [ABITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ABITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ABITS:0]   count_q, count_d;
    logic [ABITS-1:0] clr_addr_q, clr_addr_d;
    logic             pop_hs;
    logic             push_hs;

    assign count    = count_q;
    assign full     = (count_q == (ABITS+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = ram_dout;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        clr_addr_d = clr_addr_q;
        push_ready = 1'b0;
        pop_valid  = 1'b0;
        busy       = 1'b0;
        ram_wr     = 1'b0;
        ram_addr   = rd_ptr_q;
        ram_din    = '0;
        pop_hs     = 1'b0;
        push_hs    = 1'b0;

        case (state_q)
            IDLE: begin
                pop_valid  = !empty;
                // Pop wins the single address port; a pending push waits a cycle.
                push_ready = !full && !clear && !(pop_valid && pop_ready);
                pop_hs     = pop_valid && pop_ready && !clear;
                push_hs    = push_valid && push_ready;

                if (clear) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end else if (pop_hs) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    count_d  = count_q - 1'b1;
                end else if (push_hs) begin
                    ram_wr   = 1'b1;
                    ram_addr = wr_ptr_q;
                    ram_din  = push_data;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    count_d  = count_q + 1'b1;
                end
            end

            CLEAR: begin
                busy       = 1'b1;
                ram_wr     = 1'b1;
                ram_addr   = clr_addr_q;
                clr_addr_d = clr_addr_q + 1'b1;
                // The last sweep write also empties the FIFO.
                if (clr_addr_q == ABITS'(DEPTH - 1)) begin
                    state_d  = IDLE;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench: controller wired to a behavioural 32x9 RAM with combinational read.
module tb_ram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       res;
    logic       push_valid;
    logic       push_ready;
    logic [8:0] push_data;
    logic       pop_valid;
    logic       pop_ready;
    logic [8:0] pop_data;
    logic       clear;
    logic       busy;
    logic [5:0] count;
    logic       full;
    logic       empty;
    logic       ram_wr;
    logic [4:0] ram_addr;
    logic [8:0] ram_din;
    logic [8:0] ram_dout;

    logic [8:0] mem [32];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ram_fifo_ctrl dut (
        .clk        (clk),
        .res        (res),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_data  (push_data),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .pop_data   (pop_data),
        .clear      (clear),
        .busy       (busy),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .ram_wr     (ram_wr),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
    );

    // RAM model: its own reset is tied inactive, so it has none.
    always @(posedge clk) begin
        if (ram_wr) mem[ram_addr] <= ram_din;
    end
    assign ram_dout = mem[ram_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        res = 1'b0; push_valid = 1'b0; push_data = '0; pop_ready = 1'b0; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({empty, full, busy, pop_valid, push_ready, ram_wr} !== 6'b100010) begin
            n_fail++;
            $display("FAIL reset_flags got e/f/b/pv/pr/wr=%b want 100010",
                     {empty, full, busy, pop_valid, push_ready, ram_wr});
        end
        n_checks++;
        if (count !== 6'd0) begin
            n_fail++; $display("FAIL reset_count got %0d want 0", count);
        end
        res = 1'b1;
        tick();
    endtask

    task automatic test_single();
        push_valid = 1'b1; push_data = 9'h1A5;
        #1;
        n_checks++;
        if ({push_ready, ram_wr, ram_addr, ram_din} !== {1'b1, 1'b1, 5'd0, 9'h1A5}) begin
            n_fail++;
            $display("FAIL single_push got pr=%b wr=%b addr=%0d din=%h want 1 1 0 1a5",
                     push_ready, ram_wr, ram_addr, ram_din);
        end
        tick();
        push_valid = 1'b0;
        #1;
        n_checks++;
        if ({empty, pop_valid, count, pop_data} !== {1'b0, 1'b1, 6'd1, 9'h1A5}) begin
            n_fail++;
            $display("FAIL single_head got e=%b pv=%b cnt=%0d data=%h want 0 1 1 1a5",
                     empty, pop_valid, count, pop_data);
        end
        pop_ready = 1'b1;
        tick();
        pop_ready = 1'b0;
        #1;
        n_checks++;
        if ({empty, pop_valid, count} !== {1'b1, 1'b0, 6'd0}) begin
            n_fail++;
            $display("FAIL single_pop got e=%b pv=%b cnt=%0d want 1 0 0", empty, pop_valid, count);
        end
    endtask

    task automatic test_fill();
        logic [8:0] exp;
        for (int i = 0; i < 32; i++) begin
            push_valid = 1'b1; push_data = 9'(i);
            #1;
            n_checks++;
            if (push_ready !== 1'b1) begin
                n_fail++; $display("FAIL fill_ready[%0d] got %b want 1", i, push_ready);
            end
            tick();
        end
        push_data = 9'h0AA;
        #1;
        n_checks++;
        if ({full, push_ready, ram_wr, count} !== {1'b1, 1'b0, 1'b0, 6'd32}) begin
            n_fail++;
            $display("FAIL fill_full got f=%b pr=%b wr=%b cnt=%0d want 1 0 0 32",
                     full, push_ready, ram_wr, count);
        end
        tick();
        push_valid = 1'b0;
        #1;
        n_checks++;
        if (count !== 6'd32) begin
            n_fail++; $display("FAIL fill_hold got cnt=%0d want 32", count);
        end
        pop_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            exp = 9'(i);
            #1;
            n_checks++;
            if ({pop_valid, pop_data} !== {1'b1, exp}) begin
                n_fail++;
                $display("FAIL fill_pop[%0d] got pv=%b data=%h want 1 %h", i, pop_valid, pop_data, exp);
            end
            tick();
        end
        pop_ready = 1'b0;
        #1;
        n_checks++;
        if ({empty, full, count} !== {1'b1, 1'b0, 6'd0}) begin
            n_fail++; $display("FAIL fill_drained got e=%b f=%b cnt=%0d want 1 0 0", empty, full, count);
        end
    endtask

    task automatic test_wrap();
        logic [8:0] exp;
        for (int r = 0; r < 2; r++) begin
            push_valid = 1'b1;
            for (int i = 0; i < 20; i++) begin
                push_data = 9'(9'h100 + r * 20 + i);
                tick();
            end
            push_valid = 1'b0;
            pop_ready  = 1'b1;
            for (int i = 0; i < 20; i++) begin
                exp = 9'(9'h100 + r * 20 + i);
                #1;
                n_checks++;
                if ({pop_valid, pop_data} !== {1'b1, exp}) begin
                    n_fail++;
                    $display("FAIL wrap_pop[%0d.%0d] got pv=%b data=%h want 1 %h",
                             r, i, pop_valid, pop_data, exp);
                end
                tick();
            end
            pop_ready = 1'b0;
        end
        #1;
        n_checks++;
        if (count !== 6'd0) begin
            n_fail++; $display("FAIL wrap_count got %0d want 0", count);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp_q[$];
        logic [8:0] next_word;
        logic       exp_pr;
        push_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_data = 9'(9'h050 + i);
            exp_q.push_back(push_data);
            tick();
        end
        next_word  = 9'h060;
        push_data  = next_word;
        pop_ready  = 1'b1;
        for (int c = 0; c < 16; c++) begin
            exp_pr = (exp_q.size() == 0);
            #1;
            n_checks++;
            if ({push_ready, pop_valid} !== {exp_pr, !exp_pr}) begin
                n_fail++;
                $display("FAIL b2b_hs[%0d] got pr=%b pv=%b want %b %b",
                         c, push_ready, pop_valid, exp_pr, !exp_pr);
            end
            if (!exp_pr) begin
                n_checks++;
                if (pop_data !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL b2b_data[%0d] got %h want %h", c, pop_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
                tick();
            end else begin
                exp_q.push_back(next_word);
                tick();
                next_word = next_word + 9'd1;
                push_data = next_word;
            end
        end
        push_valid = 1'b0;
        while (exp_q.size() != 0) begin
            #1;
            n_checks++;
            if ({pop_valid, pop_data} !== {1'b1, exp_q[0]}) begin
                n_fail++;
                $display("FAIL b2b_drain got pv=%b data=%h want 1 %h", pop_valid, pop_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
            tick();
        end
        pop_ready = 1'b0;
        #1;
        n_checks++;
        if (empty !== 1'b1) begin
            n_fail++; $display("FAIL b2b_empty got %b want 1", empty);
        end
    endtask

    task automatic fill_ones();
        push_valid = 1'b1; push_data = 9'h1FF;
        repeat (32) tick();
        push_valid = 1'b0;
    endtask

    task automatic test_clear();
        int bad;
        fill_ones();
        clear = 1'b1;
        #1;
        n_checks++;
        if ({push_ready, busy, full} !== 3'b001) begin
            n_fail++;
            $display("FAIL clear_req got pr=%b busy=%b full=%b want 0 0 1", push_ready, busy, full);
        end
        tick();
        clear = 1'b0;
        for (int c = 0; c < 32; c++) begin
            #1;
            n_checks++;
            if ({busy, ram_wr, ram_addr, ram_din, push_ready, pop_valid} !==
                {1'b1, 1'b1, 5'(c), 9'h000, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL clear_cyc[%0d] got busy=%b wr=%b addr=%0d din=%h pr=%b pv=%b want 1 1 %0d 0 0 0",
                         c, busy, ram_wr, ram_addr, ram_din, push_ready, pop_valid, c);
            end
            tick();
        end
        #1;
        n_checks++;
        if ({busy, empty, count} !== {1'b0, 1'b1, 6'd0}) begin
            n_fail++;
            $display("FAIL clear_done got busy=%b e=%b cnt=%0d want 0 1 0", busy, empty, count);
        end
        bad = 0;
        for (int a = 0; a < 32; a++) if (mem[a] !== 9'h000) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL clear_mem got %0d nonzero words want 0", bad);
        end
    endtask

    task automatic test_reset_mid_clear();
        int bad;
        fill_ones();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (10) tick();
        res = 1'b0;
        #1;
        n_checks++;
        if ({busy, ram_wr, empty, full, pop_valid, push_ready, count} !==
            {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0}) begin
            n_fail++;
            $display("FAIL abort_outputs got busy=%b wr=%b e=%b f=%b pv=%b pr=%b cnt=%0d want 0 0 1 0 0 1 0",
                     busy, ram_wr, empty, full, pop_valid, push_ready, count);
        end
        tick();
        res = 1'b1;
        tick();
        bad = 0;
        for (int a = 0; a < 10; a++) if (mem[a] !== 9'h000) bad++;
        for (int a = 10; a < 32; a++) if (mem[a] !== 9'h1FF) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL abort_mem got %0d words with unexpected value want 0", bad);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle got busy=%b want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_wrap();
        test_back_to_back();
        test_clear();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

Sequencer that sits directly upstream of the 32×9 single-port `ram` and owns all of its ports. It presents a valid/ready push interface and a valid/ready pop interface, and turns them into a 32-deep FIFO. It arbitrates the RAM's single address port one operation per cycle. It also provides a full-array clear sweep that zeroes all 32 locations, independent of the RAM's own reset.

## Interface
- `ABITS`, 5, RAM address width.
- `DBITS`, 9, data width.
- `DEPTH`, 32, number of locations; must equal 2**ABITS.
- `clk`  in  1  sole clock, rising edge.
- `res`  in  1  reset, asynchronous, active-low.
- `push_valid`  in  1  producer has a word.
- `push_ready`  out  1  controller accepts the word this cycle.
- `push_data`  in  DBITS  word to enqueue.
- `pop_valid`  out  1  head word available.
- `pop_ready`  in  1  consumer takes the head this cycle.
- `pop_data`  out  DBITS  head word, taken combinationally from `ram_dout`.
- `clear`  in  1  request a zeroing sweep (sampled in IDLE only).
- `busy`  out  1  high while in CLEAR.
- `count`  out  ABITS+1  words held, 0..32.
- `full`  out  1  count == 32.
- `empty`  out  1  count == 0.
- `ram_wr`  out  1  to RAM write enable.
- `ram_addr`  out  ABITS  to RAM address.
- `ram_din`  out  DBITS  to RAM write data.
- `ram_dout`  in  DBITS  from RAM combinational read data.

## Operation
- Internal state: `wr_ptr`, `rd_ptr` (ABITS each, wrap 31→0), `count` (ABITS+1), sweep counter `clr_addr` (ABITS), and a 2-state FSM: IDLE, CLEAR.
- IDLE outputs:
  - `pop_valid = !empty`.
  - `push_ready = !full && !clear && !(pop_valid && pop_ready)`. Pop has priority, because both operations need `ram_addr`.
- IDLE address mux:
  - During a push handshake: `ram_addr = wr_ptr`, `ram_wr = 1`, `ram_din = push_data`.
  - Otherwise: `ram_addr = rd_ptr`, `ram_wr = 0`, `ram_din = 0`.
  - `pop_data = ram_dout` at all times. It is meaningful only while `pop_valid` is high.
- Push handshake: `wr_ptr` +1, `count` +1. Pop handshake: `rd_ptr` +1, `count` −1. Both never occur in the same cycle.
- `clear` high in IDLE:
  - Go to CLEAR on the next edge. No push or pop handshake happens that cycle, because `push_ready` is forced low and `pop_valid && pop_ready` is ignored while `clear` is high.
  - Set `clr_addr` = 0.
- CLEAR outputs:
  - `ram_wr = 1`, `ram_addr = clr_addr`, `ram_din = 0`.
  - `push_ready = 0`, `pop_valid = 0`, `busy = 1`.
  - `clr_addr` +1 each cycle.
- CLEAR exit: on the edge where `clr_addr` == 31, return to IDLE and zero `wr_ptr`, `rd_ptr` and `count`. `clear` is ignored during CLEAR.
- `full` and `empty` decode from `count`, not from pointer comparison.

## Timing
- Reset (`res` = 0, asynchronous):
  - State IDLE; `wr_ptr`, `rd_ptr`, `count`, `clr_addr` = 0.
  - Outputs: `empty` = 1, `full` = 0, `busy` = 0, `pop_valid` = 0, `push_ready` = 1 (when `clear` = 0), `ram_wr` = 0.
  - RAM contents are not touched.
- Reset mid-CLEAR aborts the sweep immediately. Locations not yet written keep their old values.
- Push latency: a word accepted at edge N is readable as `pop_data` with `pop_valid` = 1 in cycle N+1.
- Pop: `pop_data` is valid in the same cycle as `pop_valid`. The next head appears the cycle after the handshake.
- CLEAR lasts exactly 32 cycles. `busy` falls on the edge completing the address-31 write.
- Full: `push_ready` = 0 and `push_data` is ignored. Empty: `pop_valid` = 0 and `pop_ready` is ignored.
- Simultaneous `push_valid` and pop handshake: the pop completes and the push stalls one cycle. Data is never lost or duplicated.
- `push_ready` has a combinational path from `pop_ready` and `clear`.

## Structure
- Shared package `ram_pkg`:
  - Constants ABITS = 5, DBITS = 9, DEPTH = 32.
  - FSM state typedef `fifo_state_t` {IDLE, CLEAR}.
- No sub-module. Pointer, count and sweep logic stay inline.
- The verification top instantiates `ram_fifo_ctrl` wired port-for-port to the 32×9 `ram`, with the RAM's own reset tied inactive.

## Test plan
- Reset, then push 0x1A5 → `empty` falls next cycle, `count` = 1, `pop_data` = 0x1A5; pop → `empty` = 1.
- Push 32 words 0x000..0x01F → `full` = 1, `push_ready` = 0; a 33rd push is held; 32 pops return 0x000..0x01F in order.
- Push 20 and pop 20 twice (40 words total) → pointers wrap past 31 and data order is preserved.
- `push_valid` and `pop_ready` held high with `count` = 5 → pops every cycle, pushes stall until `count` = 0, then pushes resume; no data loss.
- Fill with 0x1FF, assert `clear` → `busy` high for 32 cycles, `ram_wr` = 1 on addresses 0..31 with data 0, then `count` = 0; a backdoor check shows all 32 RAM words = 0.
- Drop `res` at CLEAR cycle 10 → outputs return to reset values asynchronously; RAM addresses 10..31 still hold 0x1FF.
